// File: rtl/wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_2m
// Purpose  : Two-master / one-slave Wishbone classic round-robin arbiter; the
//            grant is held for a whole bus cycle. Define WB_ARB_TIMEOUT_EN to
//            add a watchdog that errors out transfers the slave never acks.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter_2m #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last;        // 0 = m0 owned the bus last, 1 = m1
  logic   w_last_nxt;
  logic   w_elig0;
  logic   w_elig1;
  logic   w_timeout;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] C_TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_tmo_cnt;
  logic          r_lock0;
  logic          r_lock1;
  logic          w_gnt_stb;

  assign w_gnt_stb = (r_state == ST_GRANT0) ? m0_stb_i :
                     (r_state == ST_GRANT1) ? m1_stb_i : 1'b0;
  assign w_timeout = w_gnt_stb && !s_ack_i && (r_tmo_cnt == C_TMO_LAST);
  assign w_elig0   = m0_cyc_i && !r_lock0;
  assign w_elig1   = m1_cyc_i && !r_lock1;

  // A locked-out master must drop cyc before it may compete again.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_tmo_cnt <= '0;
      r_lock0   <= 1'b0;
      r_lock1   <= 1'b0;
    end else begin
      if (!w_gnt_stb || s_ack_i || w_timeout)
        r_tmo_cnt <= '0;
      else
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      r_lock0 <= (w_timeout && (r_state == ST_GRANT0)) || (r_lock0 && m0_cyc_i);
      r_lock1 <= (w_timeout && (r_state == ST_GRANT1)) || (r_lock1 && m1_cyc_i);
    end
  end
`else
  logic [31:0] w_unused_tmo;

  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
  assign w_timeout    = 1'b0;
  assign w_elig0      = m0_cyc_i;
  assign w_elig1      = m1_cyc_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    grant_o     = 2'b00;
    s_cyc_o     = 1'b0;
    s_stb_o     = 1'b0;
    s_we_o      = 1'b0;
    s_adr_o     = '0;
    s_dat_o     = '0;
    s_sel_o     = '0;
    m0_ack_o    = 1'b0;
    m1_ack_o    = 1'b0;
    m0_err_o    = 1'b0;
    m1_err_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig0 && w_elig1)
          w_state_nxt = r_last ? ST_GRANT0 : ST_GRANT1;
        else if (w_elig0)
          w_state_nxt = ST_GRANT0;
        else if (w_elig1)
          w_state_nxt = ST_GRANT1;
      end
      ST_GRANT0: begin
        grant_o  = 2'b01;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        if (w_timeout) begin
          s_cyc_o     = 1'b0;
          s_stb_o     = 1'b0;
          m0_ack_o    = 1'b0;
          m0_err_o    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b0;
        end else if (!m0_cyc_i) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b0;
        end
      end
      ST_GRANT1: begin
        grant_o  = 2'b10;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        if (w_timeout) begin
          s_cyc_o     = 1'b0;
          s_stb_o     = 1'b0;
          m1_ack_o    = 1'b0;
          m1_err_o    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b1;
        end else if (!m1_cyc_i) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter_2m
// Purpose  : Self-checking bench for wb_arbiter_2m (directed scenarios plus a
//            randomized run against a bus-ownership reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_2m;

  localparam int TMO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [31:0] m0_adr = 0, m0_dat = 0;
  logic [3:0]  m0_sel = 0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m1_adr = 0, m1_dat = 0;
  logic [3:0]  m1_sel = 0;
  logic [31:0] s_dat = 0;
  logic        s_ack = 0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  int total = 0;
  int bad   = 0;

  wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus (0 none, 1 m0, 2 m1) and who owned it last.
  int mdl_owner = 0;
  int mdl_last  = 2;
  int mdl_stall = 0;
  bit mdl_lock0 = 0;
  bit mdl_lock1 = 0;

  function automatic bit mdl_timeout();
    bit ostb;
    ostb = (mdl_owner == 1) ? m0_stb : (mdl_owner == 2) ? m1_stb : 1'b0;
    return TMO_EN && ostb && !s_ack && (mdl_stall == TMO - 1);
  endfunction

  always @(posedge clk) begin : model
    bit tmo, ocyc, ostb, w0, w1;
    if (!rst_n) begin
      mdl_owner <= 0; mdl_last <= 2; mdl_stall <= 0;
      mdl_lock0 <= 0; mdl_lock1 <= 0;
    end else begin
      tmo  = mdl_timeout();
      ocyc = (mdl_owner == 1) ? m0_cyc : (mdl_owner == 2) ? m1_cyc : 1'b0;
      ostb = (mdl_owner == 1) ? m0_stb : (mdl_owner == 2) ? m1_stb : 1'b0;
      if (mdl_owner == 0) begin
        w0 = m0_cyc && !mdl_lock0;
        w1 = m1_cyc && !mdl_lock1;
        if (w0 && w1) mdl_owner <= (mdl_last == 2) ? 1 : 2;
        else if (w0)  mdl_owner <= 1;
        else if (w1)  mdl_owner <= 2;
        mdl_stall <= 0;
      end else begin
        if (tmo || !ocyc) begin
          mdl_owner <= 0;
          mdl_last  <= mdl_owner;
        end
        mdl_stall <= (ostb && !s_ack && !tmo) ? mdl_stall + 1 : 0;
      end
      mdl_lock0 <= (tmo && mdl_owner == 1) || (mdl_lock0 && m0_cyc);
      mdl_lock1 <= (tmo && mdl_owner == 2) || (mdl_lock1 && m1_cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    s_ack  = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    m0_adr = 32'h44; m1_adr = 32'h88;
    tick(); tick(); #1;
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant_o); end
    total++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin bad++; $display("FAIL reset_sctl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o}); end
    total++; if (s_adr_o !== 32'h0) begin bad++; $display("FAIL reset_sadr: got %h want 0", s_adr_o); end
    total++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin bad++; $display("FAIL reset_ackerr: got %b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
    idle_masters();
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_m0();
    int acks = 0;
    idle_masters(); tick();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h100; m0_sel = 4'hF;
    #1;
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL single_latency: got %b want 00", grant_o); end
    tick(); #1;
    total++; if (grant_o !== 2'b01 || s_cyc_o !== 1'b1 || s_adr_o !== 32'h100)
      begin bad++; $display("FAIL single_grant: got grant=%b cyc=%b adr=%h want 01/1/100", grant_o, s_cyc_o, s_adr_o); end
    for (int k = 0; k < 3; k++) begin
      s_ack = (k == 2);
      s_dat = (k == 2) ? 32'hCAFE_F00D : $urandom;
      #1;
      if (m0_ack_o === 1'b1) acks++;
      if (k == 2) begin
        total++; if (m0_dat_o !== 32'hCAFE_F00D || m1_dat_o !== 32'hCAFE_F00D)
          begin bad++; $display("FAIL single_rdata: got %h/%h want cafef00d", m0_dat_o, m1_dat_o); end
        total++; if (m1_ack_o !== 1'b0) begin bad++; $display("FAIL single_m1ack: got %b want 0", m1_ack_o); end
      end
      tick();
    end
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1;
    total++; if (acks !== 1) begin bad++; $display("FAIL single_ackcount: got %0d want 1", acks); end
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL single_hold: got %b want 01", grant_o); end
    tick(); #1;
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL single_release: got %b want 00", grant_o); end
  endtask

  task automatic test_tie();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20;
    tick(); #1;
    total++; if (grant_o !== 2'b01 || s_adr_o !== 32'h10)
      begin bad++; $display("FAIL tie_first: got grant=%b adr=%h want 01/10", grant_o, s_adr_o); end
    s_ack = 1; #1;
    total++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin bad++; $display("FAIL tie_ack: got %b want 10", {m0_ack_o, m1_ack_o}); end
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick(); #1;
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL tie_bubble: got %b want 00", grant_o); end
    tick(); #1;
    total++; if (grant_o !== 2'b10 || s_adr_o !== 32'h20)
      begin bad++; $display("FAIL tie_second: got grant=%b adr=%h want 10/20", grant_o, s_adr_o); end
    idle_masters(); tick(); tick();
  endtask

  task automatic test_alternate();
    bit p0 = 0, p1 = 0;
    int n0 = 0, n1 = 0;
    logic [1:0] prev_g = 2'b00, last_nz = 2'b10, exp_g;
    for (int c = 0; c < 40; c++) begin
      m0_cyc = !p0; m0_stb = !p0; m0_adr = 32'h1000 + c;
      m1_cyc = !p1; m1_stb = !p1; m1_adr = 32'h2000 + c;
      #1;
      s_ack = s_stb_o; s_dat = $urandom;
      #1;
      p0 = m0_ack_o; p1 = m1_ack_o;
      if (m0_ack_o) n0++;
      if (m1_ack_o) n1++;
      if (grant_o !== prev_g) begin
        exp_g = (prev_g != 2'b00) ? 2'b00 : ((last_nz == 2'b01) ? 2'b10 : 2'b01);
        total++; if (grant_o !== exp_g) begin bad++; $display("FAIL alt_seq: cycle %0d got %b want %b", c, grant_o, exp_g); end
        if (grant_o != 2'b00) last_nz = grant_o;
        prev_g = grant_o;
      end
      tick();
    end
    total++; if (n0 < 5 || n1 < 5) begin bad++; $display("FAIL alt_fair: got m0=%0d m1=%0d want both >=5", n0, n1); end
    idle_masters(); tick(); tick();
  endtask

  task automatic test_hold_m1();
    logic [31:0] wd [3];
    for (int i = 0; i < 3; i++) wd[i] = $urandom;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF; m1_adr = 32'h0; m1_dat = wd[0];
    tick();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h200; m0_sel = 4'h3;
    for (int i = 0; i < 3; i++) begin
      m1_adr = 32'(i * 4); m1_dat = wd[i];
      #1;
      s_ack = s_stb_o;
      #1;
      total++;
      if (grant_o !== 2'b10 || s_we_o !== 1'b1 || s_adr_o !== 32'(i * 4) || s_dat_o !== wd[i] ||
          s_sel_o !== 4'hF || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0)
        begin bad++; $display("FAIL hold_write%0d: got grant=%b we=%b adr=%h dat=%h sel=%h ack=%b%b want 10/1/%h/%h/f/10",
          i, grant_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, m1_ack_o, m0_ack_o, 32'(i * 4), wd[i]); end
      tick();
    end
    m1_cyc = 0; m1_stb = 0; m1_we = 0; s_ack = 0;
    #1;
    total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL hold_drop: got %b want 10", grant_o); end
    tick(); #1;
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL hold_bubble: got %b want 00", grant_o); end
    tick(); #1;
    total++; if (grant_o !== 2'b01 || s_adr_o !== 32'h200)
      begin bad++; $display("FAIL hold_m0after: got grant=%b adr=%h want 01/200", grant_o, s_adr_o); end
    idle_masters(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h77;
    tick(); #1;
    total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL rmid_setup: got %b want 10", grant_o); end
    m0_cyc = 1; m0_stb = 1; rst_n = 0;
    #1;
    total++; if (s_cyc_o !== 1'b1) begin bad++; $display("FAIL rmid_before_edge: got %b want 1", s_cyc_o); end
    tick(); #1;
    total++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b00)
      begin bad++; $display("FAIL rmid_dropped: got cyc=%b grant=%b want 0/00", s_cyc_o, grant_o); end
    rst_n = 1;
    tick(); #1;
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL rmid_after: got %b want 01", grant_o); end
    idle_masters(); tick(); tick();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h300; s_ack = 0;
    tick();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h400;
    for (int n = 1; n <= TMO; n++) begin
      #1;
      total++;
      if (n < TMO) begin
        if (s_cyc_o !== 1'b1 || m0_err_o !== 1'b0)
          begin bad++; $display("FAIL tmo_wait%0d: got cyc=%b err=%b want 1/0", n, s_cyc_o, m0_err_o); end
      end else begin
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m0_err_o !== 1'b1 || m0_ack_o !== 1'b0)
          begin bad++; $display("FAIL tmo_fire: got cyc=%b stb=%b err=%b ack=%b want 0/0/1/0", s_cyc_o, s_stb_o, m0_err_o, m0_ack_o); end
      end
      tick();
    end
    s_ack = 1; #1;
    total++; if (m0_ack_o !== 1'b0 || m0_err_o !== 1'b0 || grant_o !== 2'b00)
      begin bad++; $display("FAIL tmo_late: got ack=%b err=%b grant=%b want 0/0/00", m0_ack_o, m0_err_o, grant_o); end
    s_ack = 0;
    tick(); #1;
    total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL tmo_m1: got %b want 10", grant_o); end
    s_ack = 1; tick();
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL tmo_lock%0d: got %b want 00", i, grant_o); end
    end
    m0_cyc = 0; m0_stb = 0;
    tick();
    m0_cyc = 1; m0_stb = 1;
    tick(); #1;
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL tmo_regrant: got %b want 01", grant_o); end
    idle_masters(); tick(); tick();
  endtask
`endif

  task automatic test_random();
    logic [140:0] exp_v, act_v;
    logic [1:0] eg;
    logic ec, es, ew, a0, a1, e0, e1;
    logic [31:0] ea, ed;
    logic [3:0] esel;
    for (int c = 0; c < 300; c++) begin
      if (m0_cyc) m0_cyc = ($urandom % 4) != 0; else m0_cyc = ($urandom % 3) == 0;
      if (m1_cyc) m1_cyc = ($urandom % 4) != 0; else m1_cyc = ($urandom % 3) == 0;
      m0_stb = m0_cyc && (($urandom % 4) != 0);
      m1_stb = m1_cyc && (($urandom % 4) != 0);
      m0_we = $urandom; m0_adr = $urandom; m0_dat = $urandom; m0_sel = $urandom;
      m1_we = $urandom; m1_adr = $urandom; m1_dat = $urandom; m1_sel = $urandom;
      s_ack = ($urandom % 3) == 0;
      s_dat = $urandom;
      #1;
      eg = 0; ec = 0; es = 0; ew = 0; ea = 0; ed = 0; esel = 0; a0 = 0; a1 = 0; e0 = 0; e1 = 0;
      if (mdl_owner == 1) begin
        eg = 2'b01; ec = m0_cyc; es = m0_stb; ew = m0_we; ea = m0_adr; ed = m0_dat; esel = m0_sel; a0 = s_ack;
        if (mdl_timeout()) begin ec = 0; es = 0; a0 = 0; e0 = 1; end
      end else if (mdl_owner == 2) begin
        eg = 2'b10; ec = m1_cyc; es = m1_stb; ew = m1_we; ea = m1_adr; ed = m1_dat; esel = m1_sel; a1 = s_ack;
        if (mdl_timeout()) begin ec = 0; es = 0; a1 = 0; e1 = 1; end
      end
      exp_v = {eg, ec, es, ew, ea, ed, esel, a0, a1, e0, e1, s_dat, s_dat};
      act_v = {grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
               m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o};
      total++; if (act_v !== exp_v) begin bad++; $display("FAIL random c%0d: got %h want %h", c, act_v, exp_v); end
      tick();
    end
    idle_masters(); tick(); tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_single_m0();
    test_tie();
    test_alternate();
    test_hold_m1();
    test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
Two-master, one-slave Wishbone classic arbiter that shares the on-chip firmware RAM between the picorv32 master and a second master (debug/DMA loader). It sits between the masters and the RAM slave port in the system top. Round-robin fairness, with the grant held for a whole bus cycle (cyc). It also has an optional watchdog that terminates transfers the slave never acknowledges.

Parameters:
AW, 32, address width
DW, 32, data width (sel width = DW/8)
TIMEOUT_CYCLES, 255, number of stb-without-ack cycles before forced error (≥2; used only with watchdog)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  synchronous reset, active-low
m0_cyc_i / m1_cyc_i  in  1  master cycle request
m0_stb_i / m1_stb_i  in  1  master strobe
m0_we_i / m1_we_i  in  1  master write enable
m0_adr_i / m1_adr_i  in  AW  master address
m0_dat_i / m1_dat_i  in  DW  master write data
m0_sel_i / m1_sel_i  in  DW/8  master byte select
m0_dat_o / m1_dat_o  out  DW  read data (both driven from s_dat_i)
m0_ack_o / m1_ack_o  out  1  acknowledge to master
m0_err_o / m1_err_o  out  1  error to master
s_cyc_o, s_stb_o, s_we_o  out  1  slave control
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_sel_o  out  DW/8  slave byte select
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave acknowledge
grant_o  out  2  one-hot current grant (bit0=m0, bit1=m1), 00 in IDLE

Behaviour:
- Clock domain is clk_i only. Reset is synchronous and active-low on rst_n_i. All state is sampled on the clk_i rising edge.
- Reset values: state=IDLE, last=1 (so m0 wins the first tie), grant_o=00, timeout counter=0, lockout flags=0.
- Reset output behaviour: all s_* control outputs are 0 and all ack/err outputs are 0 while reset is asserted and in IDLE.
- Reset mid-transfer: the grant is dropped immediately at the reset edge. The slave sees s_cyc_o=0 from the next cycle.
- State machine, IDLE:
  - A master is eligible when its cyc=1 and its lockout flag=0.
  - Both eligible: grant the master ≠ last.
  - One eligible: grant that master.
  - None eligible: stay in IDLE.
  - The transition is registered, so there is 1 cycle of arbitration latency from cyc to s_cyc_o.
- State machine, GRANT0/GRANT1:
  - The granted master's cyc/stb/we/adr/dat/sel pass combinationally to s_*.
  - s_ack_i passes combinationally to the granted master's ack; the other master's ack/err = 0.
  - The grant is held while the granted master keeps cyc=1, including across multiple stb/ack transfers.
  - When the granted cyc=0: set last=granted and go to IDLE (one bubble cycle before any regrant).
- Outputs in IDLE: s_cyc_o=s_stb_o=s_we_o=0 and s_adr_o/s_dat_o/s_sel_o=0.
- m0_dat_o and m1_dat_o always equal s_dat_i.
- Contention: a request from the non-granted master is ignored until the grant returns to IDLE. With both masters requesting continuously, the grants strictly alternate.
- Slave ack while the granted stb=0 is forwarded unchanged. The slave is responsible for protocol correctness.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- With the macro:
  - The counter increments each granted cycle in which stb=1 and s_ack_i=0.
  - The counter clears on s_ack_i=1, on stb=0, or in IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack, the granted master's err is asserted for exactly one cycle.
  - In that same cycle s_cyc_o and s_stb_o are forced to 0.
  - The state then goes to IDLE with last=granted, and that master's lockout flag is set.
  - A lockout flag clears when its master's cyc=0.
  - A late s_ack_i arriving after a timeout is not forwarded.
- Without the macro: no counter or lockout logic exists and m0_err_o/m1_err_o are tied to 0.

Test Plan:
- Only m0 requests: m0 reads 0x100 and the slave acks 2 cycles after s_stb_o -> grant_o=01 one cycle after m0_cyc_i, m0_ack_o pulses once, m0_dat_o=slave data, grant_o=00 one cycle after m0_cyc_i drops.
- Both cyc rise in the same cycle after reset -> m0 is granted first. After m0 drops cyc: one IDLE cycle, then grant_o=10.
- Both masters request continuously, each doing 1 transfer per cycle -> the grant sequence is 01,00,10,00,01, and m1 is never starved.
- m1 holds cyc across 3 writes (adr 0x0,0x4,0x8, sel=0xF) while m0 requests -> all 3 writes reach the slave with m1 data and grant_o stays 10 throughout. m0 is granted only afterwards.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks an m0 read -> m0_err_o pulses on the 8th stb cycle, s_cyc_o=0 that cycle, then m1 is granted. m0 is not regranted until it drops and reasserts cyc.
- rst_n_i asserted low mid-transfer while granted to m1 -> s_cyc_o=0 and grant_o=00 the cycle after the reset edge. After release with both requesting, m0 is granted first.
